// File: rtl/mem_responder_if.sv
// Bus bundle between the CPU/loader/consumer side and mem_responder.
// The slave modport is the responder's view; the master modport is the driving side.
interface mem_responder_if;
  logic [15:0] Address;
  logic [7:0]  DataIn;
  logic        WE;
  logic [7:0]  DataOut;
  logic        load_start;
  logic [15:0] load_base;
  logic [15:0] load_len;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_ready;
  logic        load_done;
  logic        cpu_hold;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;

  modport slave (
    input  Address, DataIn, WE, load_start, load_base, load_len,
           load_valid, load_data, out_ready,
    output DataOut, load_ready, load_done, cpu_hold, out_valid, out_data
  );

  modport master (
    output Address, DataIn, WE, load_start, load_base, load_len,
           load_valid, load_data, out_ready,
    input  DataOut, load_ready, load_done, cpu_hold, out_valid, out_data
  );
endinterface

// File: rtl/mem_responder.sv
// CPU memory responder: aliased byte RAM, two I/O locations, a byte-stream
// loader that holds the CPU in reset, and a 4-entry output FIFO.
module mem_responder #(
  parameter int          ADDR_W  = 12,
  parameter logic [15:0] IO_DATA = 16'hFFF0,
  parameter logic [15:0] IO_STAT = 16'hFFF1
) (
  input  logic              CLK,
  input  logic              R,
  mem_responder_if.slave    bus,
  output logic [1:0]        o_dbg_state
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [15:0]       r_ptr;
  logic [15:0]       r_remain;
  logic [7:0]        r_mem [0:DEPTH-1];
  logic [7:0]        r_fifo [0:3];
  logic [1:0]        r_wr_ptr;
  logic [1:0]        r_rd_ptr;
  logic [2:0]        r_count;
  logic              r_overflow;

  logic              w_is_data;
  logic              w_is_stat;
  logic              w_is_ram;
  logic              w_hold;
  logic              w_load_xfer;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [7:0]        w_mem_wdata;
  logic              w_push_req;
  logic              w_push_ok;
  logic              w_push_rej;
  logic              w_pop;
  logic              w_stat_wr;

  assign w_is_data = (bus.Address == IO_DATA);
  assign w_is_stat = (bus.Address == IO_STAT);
  assign w_is_ram  = !w_is_data && !w_is_stat;

  assign w_hold         = (r_state == S_LOAD) || (r_state == S_DONE);
  assign bus.cpu_hold   = w_hold;
  assign bus.load_ready = (r_state == S_LOAD);
  assign bus.load_done  = (r_state == S_DONE);
  assign o_dbg_state    = r_state;

  assign w_load_xfer = (r_state == S_LOAD) && bus.load_valid;

  // Loader owns the RAM port while it runs; CPU writes are blocked by hold.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = bus.Address[ADDR_W-1:0];
    w_mem_wdata = bus.DataIn;
    if (w_load_xfer) begin
      w_mem_we    = !R;
      w_mem_addr  = r_ptr[ADDR_W-1:0];
      w_mem_wdata = bus.load_data;
    end else if (bus.WE && w_is_ram && !w_hold) begin
      w_mem_we = !R;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
  end

  always_comb begin
    bus.DataOut = r_mem[bus.Address[ADDR_W-1:0]];
    if (w_is_data)      bus.DataOut = 8'h00;
    else if (w_is_stat) bus.DataOut = {4'b0, r_overflow, r_count};
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.load_start) w_next = (bus.load_len != 16'd0) ? S_LOAD : S_DONE;
      S_LOAD: if (bus.load_valid && (r_remain == 16'd1)) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (R) begin
      r_state  <= S_IDLE;
      r_ptr    <= 16'd0;
      r_remain <= 16'd0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && bus.load_start) begin
        r_ptr    <= bus.load_base;
        r_remain <= bus.load_len;
      end else if (w_load_xfer) begin
        r_ptr    <= r_ptr + 16'd1;
        r_remain <= r_remain - 16'd1;
      end
    end
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_pop      = (r_count != 3'd0) && bus.out_ready;
  assign w_push_req = bus.WE && w_is_data && !w_hold;
  assign w_push_ok  = w_push_req && ((r_count < 3'd4) || w_pop);
  assign w_push_rej = w_push_req && !w_push_ok;
  assign w_stat_wr  = bus.WE && w_is_stat && !w_hold;

  assign bus.out_valid = (r_count != 3'd0);
  assign bus.out_data  = (r_count != 3'd0) ? r_fifo[r_rd_ptr] : 8'h00;

  always_ff @(posedge CLK) begin
    if (w_push_ok && !R) r_fifo[r_wr_ptr] <= bus.DataIn;
  end

  always_ff @(posedge CLK) begin
    if (R) begin
      r_wr_ptr   <= 2'd0;
      r_rd_ptr   <= 2'd0;
      r_count    <= 3'd0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 2'd1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
      if (w_push_rej)     r_overflow <= 1'b1;
      else if (w_stat_wr) r_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder.
module tb_mem_responder;

  logic       CLK;
  logic       R;
  logic [1:0] dbg_state;
  int         errors;
  int         checks;
  int         hold_cycles;
  int         done_pulses;
  logic [7:0] exp_q[$];

  mem_responder_if bus ();

  mem_responder #(.ADDR_W(12)) dut (
    .CLK         (CLK),
    .R           (R),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (bus.cpu_hold)  hold_cycles++;
    if (bus.load_done) done_pulses++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t reached, required completion earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.Address    = 16'h0000;
    bus.DataIn     = 8'h00;
    bus.WE         = 1'b0;
    bus.load_start = 1'b0;
    bus.load_base  = 16'h0000;
    bus.load_len   = 16'h0000;
    bus.load_valid = 1'b0;
    bus.load_data  = 8'h00;
    bus.out_ready  = 1'b0;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    bus.Address = a;
    bus.DataIn  = d;
    bus.WE      = 1'b1;
    tick();
    bus.WE      = 1'b0;
  endtask

  task automatic check_read(input string name, input logic [15:0] a, input logic [7:0] exp);
    bus.Address = a;
    settle();
    checks++;
    if (bus.DataOut !== exp) begin
      errors++;
      $display("FAIL %s: DataOut@%h got %h required %h", name, a, bus.DataOut, exp);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    R = 1'b1;
    tick();
    tick();
    R = 1'b0;
    settle();
    checks++;
    if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d required 0", dbg_state); end
    checks++;
    if ({bus.cpu_hold, bus.load_ready, bus.load_done} !== 3'b000) begin
      errors++; $display("FAIL reset_loader: hold/ready/done got %b required 000",
                         {bus.cpu_hold, bus.load_ready, bus.load_done});
    end
    checks++;
    if ({bus.out_valid, bus.out_data} !== 9'h000) begin
      errors++; $display("FAIL reset_fifo: valid/data got %b/%h required 0/00", bus.out_valid, bus.out_data);
    end
    check_read("reset_status", 16'hFFF1, 8'h00);
  endtask

  task automatic test_loader();
    logic [7:0] bytes [3];
    bytes[0] = 8'hA9; bytes[1] = 8'h05; bytes[2] = 8'hEA;
    bus.load_start = 1'b1;
    bus.load_base  = 16'h0200;
    bus.load_len   = 16'd3;
    hold_cycles = 0;
    done_pulses = 0;
    tick();
    bus.load_start = 1'b0;
    settle();
    checks++;
    if ({bus.cpu_hold, bus.load_ready} !== 2'b11) begin
      errors++; $display("FAIL load_start: hold/ready got %b required 11", {bus.cpu_hold, bus.load_ready});
    end
    for (int i = 0; i < 3; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = bytes[i];
      tick();
      bus.load_valid = 1'b0;
      if (i < 2) tick();
    end
    settle();
    checks++;
    if ({bus.load_done, bus.cpu_hold, bus.load_ready} !== 3'b110) begin
      errors++; $display("FAIL load_done_cycle: done/hold/ready got %b required 110",
                         {bus.load_done, bus.cpu_hold, bus.load_ready});
    end
    tick();
    checks++;
    if (bus.cpu_hold !== 1'b0) begin errors++; $display("FAIL load_release: hold got %b required 0", bus.cpu_hold); end
    checks++;
    if (hold_cycles !== 6) begin errors++; $display("FAIL load_hold_len: got %0d cycles required 6", hold_cycles); end
    checks++;
    if (done_pulses !== 1) begin errors++; $display("FAIL load_done_count: got %0d required 1", done_pulses); end
    check_read("load_b0", 16'h0200, 8'hA9);
    check_read("load_b1", 16'h0201, 8'h05);
    check_read("load_b2", 16'h0202, 8'hEA);
  endtask

  task automatic test_wrap();
    bus.load_start = 1'b1;
    bus.load_base  = 16'hFFFF;
    bus.load_len   = 16'd2;
    tick();
    bus.load_start = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_data  = 8'h3C;
    tick();
    bus.load_data  = 8'hC3;
    tick();
    bus.load_valid = 1'b0;
    tick();
    check_read("wrap_fff", 16'h0FFF, 8'h3C);
    check_read("wrap_000", 16'h0000, 8'hC3);
    check_read("alias_1000", 16'h1000, 8'hC3);
    check_read("alias_ffff", 16'hFFFF, 8'h3C);
  endtask

  task automatic test_zero_len();
    bus.load_start = 1'b1;
    bus.load_len   = 16'd0;
    bus.load_base  = 16'h0300;
    tick();
    bus.load_start = 1'b0;
    settle();
    checks++;
    if ({bus.load_done, bus.cpu_hold, bus.load_ready} !== 3'b110) begin
      errors++; $display("FAIL zero_len_done: done/hold/ready got %b required 110",
                         {bus.load_done, bus.cpu_hold, bus.load_ready});
    end
    tick();
    checks++;
    if ({bus.load_done, bus.cpu_hold} !== 2'b00) begin
      errors++; $display("FAIL zero_len_idle: done/hold got %b required 00", {bus.load_done, bus.cpu_hold});
    end
  endtask

  task automatic test_cpu_rw();
    cpu_write(16'h0010, 8'h11);
    bus.Address = 16'h0010;
    bus.DataIn  = 8'h5A;
    bus.WE      = 1'b1;
    settle();
    checks++;
    if (bus.DataOut !== 8'h11) begin errors++; $display("FAIL rw_old: got %h required 11", bus.DataOut); end
    tick();
    bus.WE = 1'b0;
    check_read("rw_new", 16'h0010, 8'h5A);
    // CPU write during a load must be ignored, including FIFO pushes
    bus.load_start = 1'b1;
    bus.load_base  = 16'h0500;
    bus.load_len   = 16'd1;
    tick();
    bus.load_start = 1'b0;
    cpu_write(16'h0010, 8'hFF);
    cpu_write(16'hFFF0, 8'h99);
    bus.load_valid = 1'b1;
    bus.load_data  = 8'h42;
    tick();
    bus.load_valid = 1'b0;
    tick();
    check_read("rw_blocked", 16'h0010, 8'h5A);
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rw_no_push: out_valid got %b required 0", bus.out_valid); end
    check_read("rw_load_byte", 16'h0500, 8'h42);
  endtask

  task automatic test_fifo_overflow();
    logic [7:0] exp;
    bus.out_ready = 1'b0;
    exp_q.delete();
    for (int i = 1; i <= 5; i++) begin
      cpu_write(16'hFFF0, 8'(i * 8'h11));
      if (i <= 4) exp_q.push_back(8'(i * 8'h11));
    end
    check_read("ovf_status", 16'hFFF1, 8'h0C);
    check_read("io_data_read", 16'hFFF0, 8'h00);
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      settle();
      checks++;
      if ({bus.out_valid, bus.out_data} !== {1'b1, exp}) begin
        errors++; $display("FAIL ovf_drain: valid/data got %b/%h required 1/%h", bus.out_valid, bus.out_data, exp);
      end
      tick();
    end
    bus.out_ready = 1'b0;
    check_read("ovf_empty_status", 16'hFFF1, 8'h08);
    cpu_write(16'hFFF1, 8'h00);
    check_read("ovf_cleared", 16'hFFF1, 8'h00);
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    bus.out_ready = 1'b0;
    exp_q.delete();
    for (int i = 1; i <= 4; i++) cpu_write(16'hFFF0, 8'(i * 8'h11));
    bus.out_ready = 1'b1;
    cpu_write(16'hFFF0, 8'h66);
    bus.out_ready = 1'b0;
    check_read("full_pp_status", 16'hFFF1, 8'h04);
    checks++;
    if (bus.out_data !== 8'h22) begin errors++; $display("FAIL full_pp_head: got %h required 22", bus.out_data); end
    exp_q.push_back(8'h22); exp_q.push_back(8'h33); exp_q.push_back(8'h44); exp_q.push_back(8'h66);
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      settle();
      checks++;
      if (bus.out_data !== exp) begin errors++; $display("FAIL full_pp_drain: got %h required %h", bus.out_data, exp); end
      tick();
    end
    bus.out_ready = 1'b0;
    settle();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL full_pp_empty: valid got %b required 0", bus.out_valid); end
  endtask

  task automatic test_reset_midload();
    cpu_write(16'h0401, 8'h00);
    cpu_write(16'hFFF0, 8'h77);
    bus.load_start = 1'b1;
    bus.load_base  = 16'h0400;
    bus.load_len   = 16'd3;
    tick();
    bus.load_start = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_data  = 8'hD1;
    tick();
    done_pulses    = 0;
    bus.load_data  = 8'hD2;
    R = 1'b1;
    tick();
    R = 1'b0;
    bus.load_valid = 1'b0;
    settle();
    checks++;
    if ({bus.cpu_hold, bus.load_ready, bus.out_valid} !== 3'b000) begin
      errors++; $display("FAIL midload_abort: hold/ready/valid got %b required 000",
                         {bus.cpu_hold, bus.load_ready, bus.out_valid});
    end
    tick();
    tick();
    checks++;
    if (done_pulses !== 0) begin errors++; $display("FAIL midload_no_done: got %0d pulses required 0", done_pulses); end
    check_read("midload_kept", 16'h0400, 8'hD1);
    check_read("midload_blocked", 16'h0401, 8'h00);
    bus.load_start = 1'b1;
    bus.load_base  = 16'h0401;
    bus.load_len   = 16'd1;
    tick();
    bus.load_start = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_data  = 8'hE5;
    tick();
    bus.load_valid = 1'b0;
    settle();
    checks++;
    if (bus.load_done !== 1'b1) begin errors++; $display("FAIL reload_done: got %b required 1", bus.load_done); end
    tick();
    check_read("reload_byte", 16'h0401, 8'hE5);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    hold_cycles = 0;
    done_pulses = 0;
    R = 1'b1;
    idle_inputs();
    test_reset();
    test_loader();
    test_wrap();
    test_zero_len();
    test_cpu_rw();
    test_fifo_overflow();
    test_back_to_back();
    test_reset_midload();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
